// File: rtl/fp32_mul_seq_ctrl.sv
// Sequenced IEEE-754 single-precision multiplier: a 24-cycle shift-add mantissa
// multiply followed by normalize, round-to-nearest-even and exception packing.
module fp32_mul_seq_ctrl #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic [2:0]  out_dbg_state
);

    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0]    EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [31:0]      QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MULT  = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_result;
    logic [3:0]         r_flags;
    logic               r_sign;
    logic [EW-1:0]      r_exp;
    logic [MW-1:0]      r_ma;
    logic [MW-1:0]      r_mb;
    logic [PW-1:0]      r_acc;
    logic [4:0]         r_cnt;
    logic [MAN_W-1:0]   r_mant;
    logic               r_guard;
    logic               r_sticky;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never drops and data never changes until that transfer.
    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_result    = r_result;
    assign out_flags     = r_flags;
    assign out_dbg_state = r_state;

    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic             w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic             w_sign, w_special, w_accept;
    logic [EW-1:0]    w_exp_sum;
    logic [31:0]      w_spec_result;
    logic [3:0]       w_spec_flags;

    assign w_ea     = in_a[30:23];
    assign w_eb     = in_b[30:23];
    assign w_fa     = in_a[MAN_W-1:0];
    assign w_fb     = in_b[MAN_W-1:0];
    assign w_sign   = in_a[31] ^ in_b[31];
    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
    assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
    // A zero exponent covers denormals too: they are flushed to zero silently.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    assign w_accept  = in_valid && r_in_ready;
    assign w_exp_sum = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

    always_comb begin
        w_spec_result = '0;
        w_spec_flags  = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_result   = QNAN;
            w_spec_flags[3] = w_a_snan | w_b_snan;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_result = QNAN;
            w_spec_flags  = 4'b1000;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_result = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            w_spec_result = {w_sign, 31'd0};
        end
    end

    // One multiplier bit per cycle: add into the upper half, then shift right.
    logic [MW:0] w_sum;
    assign w_sum = {1'b0, r_acc[PW-1:MW]} + (r_mb[0] ? {1'b0, r_ma} : '0);

    logic             w_round_up;
    logic [MAN_W:0]   w_mant_inc;
    logic [EW-1:0]    w_exp_rnd;
    logic             w_inexact, w_ovf, w_unf;

    assign w_round_up = r_guard && (r_sticky || r_mant[0]);
    assign w_mant_inc = {1'b0, r_mant} + {{MAN_W{1'b0}}, w_round_up};
    assign w_exp_rnd  = r_exp + {{(EW-1){1'b0}}, w_mant_inc[MAN_W]};
    assign w_inexact  = r_guard | r_sticky;
    assign w_ovf      = $signed(w_exp_rnd) >= $signed(EXP_MAX);
    assign w_unf      = w_exp_rnd[EW-1] || (w_exp_rnd == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mant      <= '0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= w_sign;
                        r_exp      <= w_exp_sum;
                        r_ma       <= {1'b1, w_fa};
                        r_mb       <= {1'b1, w_fb};
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        if (w_special) begin
                            r_result <= w_spec_result;
                            r_flags  <= w_spec_flags;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_MULT;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= {w_sum, r_acc[MW-1:1]};
                    r_mb  <= r_mb >> 1;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(MW - 1)) r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_acc[PW-1]) begin
                        r_mant   <= r_acc[PW-2:MW];
                        r_guard  <= r_acc[MW-1];
                        r_sticky <= |r_acc[MW-2:0];
                        r_exp    <= r_exp + EW'(1);
                    end else begin
                        r_mant   <= r_acc[PW-3:MW-1];
                        r_guard  <= r_acc[MW-2];
                        r_sticky <= |r_acc[MW-3:0];
                    end
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    // A carry out of the fraction leaves it zero and bumps the exponent.
                    if (w_ovf) begin
                        r_result <= {r_sign, EXP_ONES, {MAN_W{1'b0}}};
                        r_flags  <= 4'b0101;
                    end else if (w_unf) begin
                        r_result <= {r_sign, 31'd0};
                        r_flags  <= 4'b0011;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[EXP_W-1:0], w_mant_inc[MAN_W-1:0]};
                        r_flags  <= {3'b000, w_inexact};
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mul_seq_ctrl.sv
// Bench for fp32_mul_seq_ctrl: directed cases then random operands, checked against
// an arithmetic reference model of the multiply, rounding and special-value rules.
module tb_fp32_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  out_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] exp_q[$];

  fp32_mul_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags),
    .out_dbg_state (out_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: returns {is_special, flags[3:0], result[31:0]}.
  function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    longint fa, fb, ma, mb, p, q, rem, half;
    bit s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, inexact;
    logic [31:0] r;
    logic [3:0] f;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    s = a[31] ^ b[31];
    a_nan = (ea == 255) && (fa != 0);
    b_nan = (eb == 255) && (fb != 0);
    a_snan = a_nan && (fa < (64'sd1 << 22));
    b_snan = b_nan && (fb < (64'sd1 << 22));
    a_inf = (ea == 255) && (fa == 0);
    b_inf = (eb == 255) && (fb == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) begin
      return {1'b1, (a_snan || b_snan) ? 4'b1000 : 4'b0000, 32'h7FC00000};
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) return {1'b1, 4'b1000, 32'h7FC00000};
    if (a_inf || b_inf) return {1'b1, 4'b0000, s, 31'h7F800000};
    if (a_zero || b_zero) return {1'b1, 4'b0000, s, 31'h0};
    ma = fa + (64'sd1 << 23);
    mb = fb + (64'sd1 << 23);
    p = ma * mb;
    e = ea + eb - 127;
    if (p >= (64'sd1 << 47)) begin
      sh = 24;
      e = e + 1;
    end else begin
      sh = 23;
    end
    q = p >> sh;
    rem = p - (q << sh);
    half = 64'sd1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == (64'sd1 << 24)) begin
      q = q / 2;
      e = e + 1;
    end
    inexact = (rem != 0);
    if (e >= 255) begin
      r = {s, 31'h7F800000};
      f = 4'b0101;
    end else if (e <= 0) begin
      r = {s, 31'h0};
      f = 4'b0011;
    end else begin
      r = {s, 8'(e), 23'(q)};
      f = {3'b000, inexact};
    end
    return {1'b0, f, r};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 15))
      0: return {s, 31'h0};
      1: return {s, 8'h00, 23'($urandom_range(1, (1 << 23) - 1))};
      2: return {s, 8'hFF, 23'h0};
      3: return {s, 8'hFF, 1'b1, 22'($urandom_range(0, (1 << 22) - 1))};
      4: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, (1 << 22) - 1))};
      5, 6: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      default: return {s, 8'($urandom_range(64, 190)), 23'($urandom)};
    endcase
  endfunction

  // driver: one full transaction with an optional out_ready stall
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
    logic [36:0] m;
    logic [35:0] exp_v;
    int lat;
    int exp_lat;
    m = ref_mul(a, b);
    exp_q.push_back(m[35:0]);
    exp_lat = m[36] ? 1 : 27;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 64);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      check({tag, "_hold_res"}, 64'(out_result), 64'(exp_v[31:0]));
      check({tag, "_hold_flags"}, 64'(out_flags), 64'(exp_v[35:32]));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, 64'(out_result), 64'(exp_v[31:0]));
    check({tag, "_flags"}, 64'(out_flags), 64'(exp_v[35:32]));
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'(out_flags), 64'd0);
    check("rst_state", 64'(out_dbg_state), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    do_op(32'h40400000, 32'h40000000, 0, "mul_3x2");
    do_op(32'h3FC00000, 32'h3FC00000, 0, "mul_1p5sq");
    do_op(32'hC0000000, 32'h40400000, 0, "mul_sign");
    do_op(32'h3F800001, 32'h3F800001, 0, "rne_small");
    do_op(32'h3FFFFFFF, 32'h3FFFFFFF, 0, "rne_max");
    do_op(32'h7F000000, 32'h7F000000, 0, "overflow");
    do_op(32'h00800000, 32'h00800000, 0, "underflow");
    do_op(32'h7F800000, 32'h00000000, 0, "inf_x_zero");
    do_op(32'hFF800000, 32'h40000000, 0, "neg_inf");
    do_op(32'h7F800001, 32'h3F800000, 0, "snan");
    do_op(32'h00000001, 32'h3F800000, 0, "denorm");
    do_op(32'h7FC00000, 32'h3F800000, 0, "qnan");
    do_op(32'h40490FDB, 32'hBFB504F3, 5, "stall");

    // abort in the middle of MULT
    in_a = 32'h40400000;
    in_b = 32'h40000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("mid_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'(out_result), 64'd0);
    check("abort_flags", 64'(out_flags), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_no_valid", 64'(out_valid), 64'd0);
    do_op(32'h3FC00000, 32'h3FC00000, 0, "post_rst");

    for (int k = 0; k < 40; k++) begin
      do_op(rand_operand(), rand_operand(), int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
